dma_xfer_scheduler: RTL and testbench
=====================================

# dma_xfer_scheduler

Multi-channel DMA transfer scheduler placed directly in front of the DMA AXI adapter. It accepts copy descriptors from up to NUM_CH requesters and arbitrates between them round-robin. For each accepted descriptor it runs a read phase on the adapter, then a write phase to the destination, and reports completion or timeout per channel. Only one transfer is ever outstanding on the adapter.

## Interface
Parameters:
- NUM_CH, 4: number of requesting channels (2..8).
- AXI_ID_WIDTH, 10: adapter ID width. Must be at least clog2(NUM_CH)+1.
- AXI_ADDR_WIDTH, 64: address width.
- AXI_BE_WIDTH, 8: byte-enable width.
- AXI_LEN_WIDTH, 8: burst length width (beats minus 1).
- AXI_SIZE_WIDTH, 3: beat size encoding width.
- TIMEOUT, 1024: maximum cycles spent waiting for adapter completion (at least 2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- ch_req_i  in  NUM_CH  per-channel request, held until ch_gnt_o.
- ch_src_i  in  NUM_CH x AXI_ADDR_WIDTH  source address.
- ch_dst_i  in  NUM_CH x AXI_ADDR_WIDTH  destination address.
- ch_len_i  in  NUM_CH x AXI_LEN_WIDTH  beats minus 1.
- ch_size_i  in  NUM_CH x AXI_SIZE_WIDTH  beat size.
- ch_gnt_o  out  NUM_CH  one-hot, one-cycle pulse: descriptor accepted.
- ch_done_o  out  NUM_CH  one-cycle pulse: transfer completed.
- ch_err_o  out  NUM_CH  one-cycle pulse: transfer aborted by timeout.
- busy_o  out  1  high whenever state is not IDLE.
- id_err_o  out  1  one-cycle pulse: completion arrived with an unexpected ID.
- req_o  out  1  adapter request.
- type_o  out  1  1 = single beat, 0 = burst.
- gnt_i  in  1  adapter grant.
- addr_o  out  AXI_ADDR_WIDTH  adapter address.
- we_o  out  1  1 = write phase.
- be_o  out  AXI_BE_WIDTH  byte enables.
- len_o  out  AXI_LEN_WIDTH  burst length.
- size_o  out  AXI_SIZE_WIDTH  beat size.
- id_o  out  AXI_ID_WIDTH  transaction ID.
- valid_i  in  1  adapter completion.
- id_i  in  AXI_ID_WIDTH  completion ID.

## Operation
States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.

- **IDLE:**
  - If any ch_req_i is high, select the winner. The search starts at rr_q+1 and wraps at NUM_CH-1.
  - Pulse ch_gnt_o[winner] combinationally in that cycle.
  - Latch src, dst, len, size and the winner index idx_q.
  - Go to RD_REQ.
- **RD_REQ:**
  - req_o=1, we_o=0, addr_o=src_q.
  - Stay until gnt_i, then go to RD_WAIT.
- **RD_WAIT:**
  - valid_i with id_i equal to expected ID: go to WR_REQ.
  - valid_i with any other ID: pulse id_err_o, stay in RD_WAIT.
- **WR_REQ:**
  - req_o=1, we_o=1, addr_o=dst_q.
  - Stay until gnt_i, then go to WR_WAIT.
- **WR_WAIT:** same as RD_WAIT, except a matching completion goes to FINISH with ok_q=1.
- **FINISH:**
  - Pulse ch_done_o[idx_q] if ok_q=1, else ch_err_o[idx_q].
  - Set rr_q=idx_q.
  - Go to IDLE.

Field rules:
- type_o=1 when len_q==0, else 0.
- len_o=len_q, size_o=size_q.
- be_o is all ones.
- ID = zero-extended {phase, idx_q}. phase is 0 for read, 1 for write, and sits at bit clog2(NUM_CH).
- Outside RD_REQ/WR_REQ, all adapter outputs hold their last values and req_o=0.

Watchdog:
- wd_q clears on entry to RD_WAIT and on entry to WR_WAIT, and increments every cycle spent in either state.
- If wd_q==TIMEOUT-1 and no matching valid_i arrives that cycle, go to FINISH with ok_q=0.
- A matching valid_i in the same cycle as expiry wins; the transfer counts as success.
- The watchdog does not run in the REQ states, because the adapter is allowed to backpressure indefinitely.

## Timing
- Reset values:
  - state IDLE, rr_q=NUM_CH-1 (so channel 0 wins first after reset), wd_q=0, ok_q=0, idx_q=0.
  - All outputs 0 after reset.
- A reset mid-transfer returns to IDLE immediately. No pulses are produced for the aborted transfer.
- Latency:
  - ch_gnt_o to first req_o: 1 cycle.
  - Matching write-phase valid_i to ch_done_o: 1 cycle.
  - FINISH to next ch_gnt_o: at least 1 cycle, since IDLE occupies one cycle.
- gnt_i is sampled only in the REQ states.
- valid_i is sampled only in the WAIT states; valid_i in any other state is ignored with no id_err_o.
- Channel requests arriving while busy wait. They are not queued; ch_req_i must stay high.
- Any ch_req_i that drops before being granted is simply not considered.

## Test plan
- **Single-beat copy:** ch_req_i=4'b0001, len=0, src=0x1000, dst=0x2000; gnt_i one cycle after req_o; valid_i with ID 0x000 and then 0x004 (NUM_CH=4) → type_o=1; the read addr_o is 0x1000; the write addr_o is 0x2000; ch_done_o=4'b0001 exactly one cycle after the write valid.
- **Round-robin:** ch_req_i=4'b1111 held for four transfers → grant order 0, 1, 2, 3, and ch_gnt_o is one-hot each time.
- **Burst with backpressure:** len=15; gnt_i delayed 20 cycles in RD_REQ → req_o stays high throughout; len_o=15 and type_o=0; no timeout fires.
- **Timeout:** TIMEOUT=8; valid_i is never returned in RD_WAIT → ch_err_o[idx] pulses 9 cycles after gnt_i; no ch_done_o; the next channel is served afterwards.
- **Wrong ID:** valid_i with ID 0x003 while ID 0x001 is expected → id_err_o pulses for 1 cycle, state is unchanged, and a later correct ID completes normally.
- **Reset mid-transfer:** rst_ni asserted in WR_WAIT → all outputs 0; after release, ch_req_i=4'b1010 grants channel 1 first.

Source files
------------

// File: rtl/dma_xfer_scheduler.sv
// Round-robin DMA copy scheduler: grants one channel descriptor at a time and
// drives a read phase then a write phase on a single-outstanding AXI adapter.
module dma_xfer_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int AXI_ID_WIDTH   = 10,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_BE_WIDTH   = 8,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_SIZE_WIDTH = 3,
  parameter int TIMEOUT        = 1024
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NUM_CH-1:0]                         ch_req_i,
  input  logic [NUM_CH-1:0][AXI_ADDR_WIDTH-1:0]     ch_src_i,
  input  logic [NUM_CH-1:0][AXI_ADDR_WIDTH-1:0]     ch_dst_i,
  input  logic [NUM_CH-1:0][AXI_LEN_WIDTH-1:0]      ch_len_i,
  input  logic [NUM_CH-1:0][AXI_SIZE_WIDTH-1:0]     ch_size_i,
  output logic [NUM_CH-1:0]                         ch_gnt_o,
  output logic [NUM_CH-1:0]                         ch_done_o,
  output logic [NUM_CH-1:0]                         ch_err_o,
  output logic                                      busy_o,
  output logic                                      id_err_o,
  output logic                                      req_o,
  output logic                                      type_o,
  input  logic                                      gnt_i,
  output logic [AXI_ADDR_WIDTH-1:0]                 addr_o,
  output logic                                      we_o,
  output logic [AXI_BE_WIDTH-1:0]                   be_o,
  output logic [AXI_LEN_WIDTH-1:0]                  len_o,
  output logic [AXI_SIZE_WIDTH-1:0]                 size_o,
  output logic [AXI_ID_WIDTH-1:0]                   id_o,
  input  logic                                      valid_i,
  input  logic [AXI_ID_WIDTH-1:0]                   id_i
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    FINISH
  } state_e;

  state_e r_state, w_stateNext;

  logic [IDX_W-1:0]          r_rr;
  logic [IDX_W-1:0]          r_idx;
  logic [AXI_ADDR_WIDTH-1:0] r_dst;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic                      r_we;
  logic                      r_type;
  logic [AXI_BE_WIDTH-1:0]   r_be;
  logic [AXI_LEN_WIDTH-1:0]  r_len;
  logic [AXI_SIZE_WIDTH-1:0] r_size;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [WD_W-1:0]           r_wd;
  logic                      r_ok;

  logic [IDX_W-1:0]          w_winIdx;
  logic                      w_winValid;
  logic                      w_isWait;
  logic                      w_phase;
  logic [AXI_ID_WIDTH-1:0]   w_expId;
  logic                      w_match;
  logic                      w_expire;

  // Candidate channel 'off' positions after the last served one, wrapping once.
  function automatic logic [IDX_W-1:0] rrCand(input logic [IDX_W-1:0] base, input int off);
    int c;
    c = int'(base) + off;
    if (c >= NUM_CH) c = c - NUM_CH;
    return IDX_W'(c);
  endfunction

  always_comb begin
    w_winValid = 1'b0;
    w_winIdx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!w_winValid && ch_req_i[rrCand(r_rr, i)]) begin
        w_winValid = 1'b1;
        w_winIdx   = rrCand(r_rr, i);
      end
    end
  end

  assign w_isWait = (r_state == RD_WAIT) || (r_state == WR_WAIT);
  assign w_phase  = (r_state == WR_WAIT);
  assign w_expId  = AXI_ID_WIDTH'({w_phase, r_idx});
  assign w_match  = w_isWait && valid_i && (id_i == w_expId);
  assign w_expire = (r_wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_stateNext;
  end

  // A matching completion takes priority over watchdog expiry in the same cycle.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_winValid) w_stateNext = RD_REQ;
      RD_REQ:  if (gnt_i) w_stateNext = RD_WAIT;
      RD_WAIT: begin
        if (w_match)       w_stateNext = WR_REQ;
        else if (w_expire) w_stateNext = FINISH;
      end
      WR_REQ:  if (gnt_i) w_stateNext = WR_WAIT;
      WR_WAIT: if (w_match || w_expire) w_stateNext = FINISH;
      FINISH:  w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr   <= IDX_W'(NUM_CH - 1);
      r_idx  <= '0;
      r_dst  <= '0;
      r_addr <= '0;
      r_we   <= 1'b0;
      r_type <= 1'b0;
      r_be   <= '0;
      r_len  <= '0;
      r_size <= '0;
      r_id   <= '0;
      r_wd   <= '0;
      r_ok   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_winValid) begin
            r_idx  <= w_winIdx;
            r_dst  <= ch_dst_i[w_winIdx];
            r_addr <= ch_src_i[w_winIdx];
            r_we   <= 1'b0;
            r_len  <= ch_len_i[w_winIdx];
            r_size <= ch_size_i[w_winIdx];
            r_type <= (ch_len_i[w_winIdx] == '0);
            r_be   <= '1;
            r_id   <= AXI_ID_WIDTH'({1'b0, w_winIdx});
          end
        end
        RD_REQ, WR_REQ: begin
          if (gnt_i) r_wd <= '0;
        end
        RD_WAIT: begin
          r_wd <= r_wd + WD_W'(1);
          if (w_match) begin
            r_addr <= r_dst;
            r_we   <= 1'b1;
            r_id   <= AXI_ID_WIDTH'({1'b1, r_idx});
          end else if (w_expire) begin
            r_ok <= 1'b0;
          end
        end
        WR_WAIT: begin
          r_wd <= r_wd + WD_W'(1);
          if (w_match)       r_ok <= 1'b1;
          else if (w_expire) r_ok <= 1'b0;
        end
        FINISH: r_rr <= r_idx;
        default: ;
      endcase
    end
  end

  always_comb begin
    ch_gnt_o  = '0;
    ch_done_o = '0;
    ch_err_o  = '0;
    req_o     = 1'b0;
    id_err_o  = 1'b0;
    busy_o    = (r_state != IDLE);
    case (r_state)
      IDLE:             if (w_winValid) ch_gnt_o[w_winIdx] = 1'b1;
      RD_REQ, WR_REQ:   req_o = 1'b1;
      RD_WAIT, WR_WAIT: id_err_o = valid_i && !w_match;
      FINISH: begin
        if (r_ok) ch_done_o[r_idx] = 1'b1;
        else      ch_err_o[r_idx]  = 1'b1;
      end
      default: ;
    endcase
  end

  assign addr_o = r_addr;
  assign we_o   = r_we;
  assign type_o = r_type;
  assign be_o   = r_be;
  assign len_o  = r_len;
  assign size_o = r_size;
  assign id_o   = r_id;

endmodule

// File: tb/tb_dma_xfer_scheduler.sv
// Testbench for dma_xfer_scheduler: directed vector table, multi-cycle corner
// sequences and randomized transfers checked against a round-robin model.
module tb_dma_xfer_scheduler;

  localparam int NUM_CH = 4;
  localparam int IDW    = 10;
  localparam int AW     = 64;
  localparam int BEW    = 8;
  localparam int LW     = 8;
  localparam int SW     = 3;
  localparam int TO     = 8;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [NUM_CH-1:0]         ch_req_i;
  logic [NUM_CH-1:0][AW-1:0] ch_src_i;
  logic [NUM_CH-1:0][AW-1:0] ch_dst_i;
  logic [NUM_CH-1:0][LW-1:0] ch_len_i;
  logic [NUM_CH-1:0][SW-1:0] ch_size_i;
  logic [NUM_CH-1:0]         ch_gnt_o;
  logic [NUM_CH-1:0]         ch_done_o;
  logic [NUM_CH-1:0]         ch_err_o;
  logic                      busy_o;
  logic                      id_err_o;
  logic                      req_o;
  logic                      type_o;
  logic                      gnt_i;
  logic [AW-1:0]             addr_o;
  logic                      we_o;
  logic [BEW-1:0]            be_o;
  logic [LW-1:0]             len_o;
  logic [SW-1:0]             size_o;
  logic [IDW-1:0]            id_o;
  logic                      valid_i;
  logic [IDW-1:0]            id_i;

  int checks   = 0;
  int failures = 0;
  int modelLast;

  typedef struct {
    logic [NUM_CH-1:0] mask;
    int                expCh;
    int                len;
    int                gntDelay;
    int                rdDelay;
    int                wrDelay;
    int                toPhase;
    int                wrongId;
    bit                noise;
  } vec_t;

  vec_t vecs[11];

  always #5 clk_i = ~clk_i;

  dma_xfer_scheduler #(
    .NUM_CH(NUM_CH), .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_BE_WIDTH(BEW),
    .AXI_LEN_WIDTH(LW), .AXI_SIZE_WIDTH(SW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ch_req_i(ch_req_i), .ch_src_i(ch_src_i), .ch_dst_i(ch_dst_i),
    .ch_len_i(ch_len_i), .ch_size_i(ch_size_i),
    .ch_gnt_o(ch_gnt_o), .ch_done_o(ch_done_o), .ch_err_o(ch_err_o),
    .busy_o(busy_o), .id_err_o(id_err_o),
    .req_o(req_o), .type_o(type_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o),
    .be_o(be_o), .len_o(len_o), .size_o(size_o), .id_o(id_o),
    .valid_i(valid_i), .id_i(id_i)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference arbitration: first requester strictly after the last served one, circularly.
  function automatic int predictWinner(input logic [NUM_CH-1:0] mask, input int last);
    for (int off = 1; off <= NUM_CH; off++) begin
      if (mask[(last + off) % NUM_CH]) return (last + off) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Ctl"}, 64'({ch_gnt_o, ch_done_o, ch_err_o, busy_o, id_err_o, req_o, type_o, we_o}), 64'(0));
    checkOutput({tag, "Addr"}, addr_o, 64'(0));
    checkOutput({tag, "Fields"}, 64'({be_o, len_o, size_o, id_o}), 64'(0));
  endtask

  task automatic reqPhase(input string tag, input int delay, input bit noise);
    bit held;
    held = 1'b1;
    for (int k = 0; k < delay; k++) begin
      gnt_i   = 1'b0;
      valid_i = noise;
      id_i    = IDW'($urandom);
      #1;
      if (req_o !== 1'b1) held = 1'b0;
      if (noise) checkOutput({tag, "IgnoredValid"}, 64'(id_err_o), 64'(0));
      @(negedge clk_i);
    end
    gnt_i   = 1'b1;
    valid_i = 1'b0;
    #1;
    if (req_o !== 1'b1) held = 1'b0;
    checkOutput({tag, "ReqHeld"}, 64'(held), 64'(1));
    @(negedge clk_i);
    gnt_i = 1'b0;
  endtask

  task automatic waitPhase(input string tag, input int expId, input int delay, input bit timeout,
                           input int wrongId, input logic [NUM_CH-1:0] oneHot);
    int  n;
    bit  seen;
    if (timeout) begin
      valid_i = 1'b0;
      n = 0;
      #1;
      seen = (ch_err_o != '0);
      while (!seen && n < 20) begin
        @(negedge clk_i);
        n++;
        #1;
        seen = (ch_err_o != '0);
      end
      checkOutput({tag, "ToLatency"}, 64'(n), 64'(TO));
      checkOutput({tag, "ToErr"}, 64'(ch_err_o), 64'(oneHot));
      checkOutput({tag, "ToNoDone"}, 64'(ch_done_o), 64'(0));
      @(negedge clk_i);
      #1;
      checkOutput({tag, "ToIdle"}, 64'(busy_o), 64'(0));
      return;
    end
    if (wrongId >= 0) begin
      valid_i = 1'b1;
      id_i    = IDW'(wrongId);
      #1;
      checkOutput({tag, "IdErr"}, 64'(id_err_o), 64'(1));
      @(negedge clk_i);
      valid_i = 1'b0;
      #1;
      checkOutput({tag, "IdErrHold"}, 64'({busy_o, req_o, id_err_o}), 64'(3'b100));
    end
    for (int k = 0; k < delay; k++) begin
      valid_i = 1'b0;
      @(negedge clk_i);
    end
    valid_i = 1'b1;
    id_i    = IDW'(expId);
    #1;
    checkOutput({tag, "NoIdErr"}, 64'(id_err_o), 64'(0));
    checkOutput({tag, "NoEarlyDone"}, 64'({ch_done_o, ch_err_o}), 64'(0));
    @(negedge clk_i);
    valid_i = 1'b0;
    #1;
  endtask

  task automatic applyStimulus(input int expCh, input logic [NUM_CH-1:0] mask, input int gntDelay,
                               input int rdDelay, input int wrDelay, input int toPhase,
                               input int wrongId, input bit noise);
    logic [NUM_CH-1:0] oneHot;
    oneHot        = '0;
    oneHot[expCh] = 1'b1;
    ch_req_i = mask;
    gnt_i    = 1'b0;
    valid_i  = 1'b0;
    #1;
    checkOutput("gnt", 64'(ch_gnt_o), 64'(oneHot));
    checkOutput("idleBusy", 64'(busy_o), 64'(0));
    @(negedge clk_i);
    ch_req_i = mask & ~oneHot;
    #1;
    checkOutput("rdCtl", 64'({req_o, we_o, busy_o}), 64'(3'b101));
    checkOutput("rdAddr", addr_o, ch_src_i[expCh]);
    checkOutput("rdLen", 64'(len_o), 64'(ch_len_i[expCh]));
    checkOutput("rdType", 64'(type_o), 64'(ch_len_i[expCh] == 0));
    checkOutput("rdSize", 64'(size_o), 64'(ch_size_i[expCh]));
    checkOutput("rdBe", 64'(be_o), 64'(8'hFF));
    checkOutput("rdId", 64'(id_o), 64'(expCh));
    checkOutput("gntOnce", 64'(ch_gnt_o), 64'(0));
    reqPhase("rd", gntDelay, noise);
    waitPhase("rd", expCh, rdDelay, toPhase == 1, wrongId, oneHot);
    if (toPhase == 1) return;
    checkOutput("wrCtl", 64'({req_o, we_o, busy_o}), 64'(3'b111));
    checkOutput("wrAddr", addr_o, ch_dst_i[expCh]);
    checkOutput("wrId", 64'(id_o), 64'(NUM_CH + expCh));
    checkOutput("wrLen", 64'(len_o), 64'(ch_len_i[expCh]));
    reqPhase("wr", gntDelay, noise);
    waitPhase("wr", NUM_CH + expCh, wrDelay, toPhase == 2, -1, oneHot);
    if (toPhase == 2) return;
    checkOutput("done", 64'(ch_done_o), 64'(oneHot));
    checkOutput("doneNoErr", 64'(ch_err_o), 64'(0));
    @(negedge clk_i);
    #1;
    checkOutput("doneIdle", 64'({busy_o, ch_done_o}), 64'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [NUM_CH-1:0] rmask;
    int rch, rsel, gd, rd, wr, toP, wid;
    bit nz;

    vecs[0]  = '{4'b0001, 0, 0,  1,  0, 0, 0, -1, 1'b0};
    vecs[1]  = '{4'b1111, 1, 3,  0,  2, 1, 0, -1, 1'b0};
    vecs[2]  = '{4'b1111, 2, 1,  2,  0, 3, 0, -1, 1'b1};
    vecs[3]  = '{4'b1111, 3, 4,  0,  1, 0, 0, -1, 1'b0};
    vecs[4]  = '{4'b1111, 0, 2,  1,  0, 0, 0, -1, 1'b0};
    vecs[5]  = '{4'b0100, 2, 15, 20, 0, 0, 0, -1, 1'b1};
    vecs[6]  = '{4'b1000, 3, 5,  0,  0, 0, 1, -1, 1'b0};
    vecs[7]  = '{4'b1001, 0, 2,  0,  1, 1, 0, -1, 1'b0};
    vecs[8]  = '{4'b0010, 1, 0,  0,  2, 0, 0, 3,  1'b0};
    vecs[9]  = '{4'b0110, 2, 7,  0,  7, 7, 0, -1, 1'b0};
    vecs[10] = '{4'b1010, 3, 6,  1,  0, 0, 2, -1, 1'b0};

    rst_ni = 1'b0;
    ch_req_i = '0; ch_src_i = '0; ch_dst_i = '0; ch_len_i = '0; ch_size_i = '0;
    gnt_i = 1'b0; valid_i = 1'b0; id_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    checkAllZero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    modelLast = NUM_CH - 1;
    #1;

    for (int v = 0; v < 11; v++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ch_src_i[c]  = 64'h1000 + 64'(c) * 64'h100;
        ch_dst_i[c]  = 64'h2000 + 64'(c) * 64'h100;
        ch_len_i[c]  = LW'(vecs[v].len);
        ch_size_i[c] = SW'(c);
      end
      applyStimulus(vecs[v].expCh, vecs[v].mask, vecs[v].gntDelay, vecs[v].rdDelay,
                    vecs[v].wrDelay, vecs[v].toPhase, vecs[v].wrongId, vecs[v].noise);
      modelLast = vecs[v].expCh;
    end

    // Abort a channel-2 transfer in the write wait phase with an asynchronous reset.
    ch_req_i = 4'b0100;
    #1;
    checkOutput("rstSeqGnt", 64'(ch_gnt_o), 64'(4'b0100));
    @(negedge clk_i);
    ch_req_i = '0;
    gnt_i = 1'b1;
    @(negedge clk_i);
    gnt_i = 1'b0; valid_i = 1'b1; id_i = IDW'(2);
    @(negedge clk_i);
    valid_i = 1'b0; gnt_i = 1'b1;
    @(negedge clk_i);
    gnt_i = 1'b0;
    #1;
    checkOutput("rstSeqWrWait", 64'({busy_o, req_o, we_o}), 64'(3'b101));
    rst_ni = 1'b0;
    #1;
    checkAllZero("midReset");
    @(negedge clk_i);
    #1;
    checkAllZero("midResetHeld");
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    modelLast = NUM_CH - 1;
    applyStimulus(1, 4'b1010, 0, 0, 0, 0, -1, 1'b0);
    modelLast = 1;

    for (int t = 0; t < 40; t++) begin
      rmask = NUM_CH'($urandom_range(1, 15));
      for (int c = 0; c < NUM_CH; c++) begin
        ch_src_i[c]  = {$urandom, $urandom};
        ch_dst_i[c]  = {$urandom, $urandom};
        ch_len_i[c]  = ($urandom_range(0, 3) == 0) ? '0 : LW'($urandom_range(1, 255));
        ch_size_i[c] = SW'($urandom_range(0, 7));
      end
      rch  = predictWinner(rmask, modelLast);
      rsel = $urandom_range(0, 9);
      toP  = (rsel == 0) ? 1 : (rsel == 1) ? 2 : 0;
      gd   = $urandom_range(0, 4);
      rd   = $urandom_range(0, TO - 1);
      wr   = $urandom_range(0, TO - 1);
      wid  = ($urandom_range(0, 3) == 0 && rd < TO - 1) ? (rch + 1) % NUM_CH : -1;
      nz   = 1'($urandom_range(0, 1));
      applyStimulus(rch, rmask, gd, rd, wr, toP, wid, nz);
      modelLast = rch;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
